// File: rtl/uk101_pkg.sv
// uk101_pkg: shared types and helpers for the UK101 serial capture path.
//   rx_state_t  - receive FSM encoding
//   bit_period  - clocks per serial bit for a given clock and baud select
//   BAUD_FAST / BAUD_SLOW - the two baud rates selectable from the OSD
`timescale 1ns/1ps
package uk101_pkg;

  localparam int BAUD_FAST = 9600;
  localparam int BAUD_SLOW = 300;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // baud_sel: 0 = 9600, 1 = 300. Integer division, truncating.
  function automatic int bit_period(input int clk_hz, input logic baud_sel);
    return baud_sel ? (clk_hz / BAUD_SLOW) : (clk_hz / BAUD_FAST);
  endfunction

endpackage

// File: rtl/ascii_capture_ram.sv
// ascii_capture_ram: simple dual-port byte buffer, DEPTH = 2**ADDR_W.
//   clk          - clock
//   we/waddr/wdata - write port (receive side)
//   re/raddr     - read port enable / address (upload side)
//   rdata        - registered read data, updated only when re is high
// No reset: contents are only reachable below the stored length.
`timescale 1ns/1ps
module ascii_capture_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ascii_capture.sv
// ascii_capture: decodes the UK101 ACIA TXD line (8N1) into a byte buffer
// that hps_io uploads as a text file.
//   clk, n_reset        - system clock, async active-low reset
//   baud_rate           - 0 = 9600, 1 = 300; latched at start-bit detection
//   rxd                 - asynchronous serial line, idles high
//   capture_en          - store decoded bytes when high
//   clear               - one-cycle pulse: empty buffer, clear flags, abort frame
//   ioctl_upload/rd/addr- upload read interface from hps_io
//   ioctl_din           - upload read data, one cycle after ioctl_rd
//   captured_len        - bytes stored, 0..DEPTH
//   overflow, frame_err - sticky error flags
//   busy                - receive FSM not idle
`timescale 1ns/1ps
module ascii_capture
  import uk101_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int ADDR_W   = 12,
  parameter bit DROP_NUL = 1'b1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              baud_rate,
  input  logic              rxd,
  input  logic              capture_en,
  input  logic              clear,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [15:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W:0]   captured_len,
  output logic              overflow,
  output logic              frame_err,
  output logic              busy
);

  localparam int DEPTH   = 2**ADDR_W;
  // Counter sized for the slow rate, the longest period.
  localparam int BIT_MAX = bit_period(CLK_HZ, 1'b1);
  localparam int CNT_W   = $clog2(BIT_MAX + 1);

  localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // rxd synchroniser plus one delay stage for falling-edge detect
  logic rx_meta, rxs, rxs_d;

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] bit_len, bit_len_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg;
  logic             shift_en, stop_ok, stop_bad;

  logic             acc_vld;
  logic [ADDR_W:0]  wr_ptr;
  logic             full, store_ok, we;

  logic             rd_ok;
  logic [7:0]       ram_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_len <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_len <= bit_len_nxt;
      bit_idx <= bit_idx_nxt;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_len_nxt = bit_len;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          // Baud selection is frozen here for the whole frame.
          bit_len_nxt = CNT_W'(bit_period(CLK_HZ, baud_rate));
          cnt_nxt     = (bit_len_nxt >> 1) - CNT_ONE;
          state_nxt   = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rxs) begin
            state_nxt   = DATA;
            cnt_nxt     = bit_len - CNT_ONE;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_en    = 1'b1;
          cnt_nxt     = bit_len - CNT_ONE;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        // Line must return high first so a break is not taken as a start.
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  // Accepted byte sits in shreg one cycle; store decision is made then.
  assign full     = (wr_ptr == FULL);
  assign store_ok = acc_vld && capture_en && !ioctl_upload &&
                    !(DROP_NUL && (shreg == 8'h00));
  assign we       = store_ok && !full && !clear;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_vld   <= 1'b0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      acc_vld <= stop_ok;
      if (clear) begin
        wr_ptr    <= '0;
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (we)               wr_ptr    <= wr_ptr + 1'b1;
        if (store_ok && full) overflow  <= 1'b1;
        if (stop_bad)         frame_err <= 1'b1;
      end
    end
  end

  assign captured_len = wr_ptr;

  // Range check is captured with the read so stale RAM beyond the
  // stored length reads back as zero.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)      rd_ok <= 1'b0;
    else if (ioctl_rd) rd_ok <= ({1'b0, ioctl_addr} < 17'(captured_len));
  end

  assign ioctl_din = rd_ok ? ram_q : 8'h00;

  ascii_capture_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (shreg),
    .re    (ioctl_rd),
    .raddr (ioctl_addr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

endmodule

// File: doc/ascii_capture.md
Name: ascii_capture

Overview:
- "Save Ascii" path: the inverse of the existing "Load Ascii" ioctl download.
- Taps the UK101 serial transmit line (ACIA TXD, 8N1, 9600 or 300 baud per OSD) and decodes the frames.
- Stores received bytes in an on-chip buffer.
- Serves the buffer to hps_io through the ioctl upload interface so the HPS can write it out as a .TXT file.
- Instantiated in emu beside uk101, clocked from clk_sys.

Parameters:
- CLK_HZ, 50000000: clk frequency in Hz. Bit periods derive from it.
- ADDR_W, 12: buffer address width; DEPTH = 2**ADDR_W bytes.
- DROP_NUL, 1: when 1, received 0x00 bytes are discarded (UK101 pads lines with NULs).

Ports:
- clk, in, 1: system clock (clk_sys).
- n_reset, in, 1: asynchronous active-low reset.
- baud_rate, in, 1: 0 = 9600, 1 = 300. Sampled only at start-bit detection.
- rxd, in, 1: serial line from uk101 txd. Asynchronous; idles high.
- capture_en, in, 1: 1 = store decoded bytes; 0 = decode but discard.
- clear, in, 1: one-cycle pulse. Empties the buffer and clears the flags.
- ioctl_upload, in, 1: high while the HPS is reading the buffer.
- ioctl_rd, in, 1: read strobe from hps_io.
- ioctl_addr, in, 16: byte address of the upload read.
- ioctl_din, out, 8: upload read data.
- captured_len, out, ADDR_W+1: number of bytes stored, 0..DEPTH.
- overflow, out, 1: sticky; a byte was dropped because the buffer was full.
- frame_err, out, 1: sticky; a stop bit was sampled low.
- busy, out, 1: high while the receive FSM is not in IDLE.

Behaviour:
- Reset (n_reset low, async):
  - FSM goes to IDLE; wr_ptr = 0.
  - Outputs: captured_len = 0, overflow = 0, frame_err = 0, busy = 0, ioctl_din = 0x00.
  - Buffer contents are undefined but unreachable, since captured_len = 0.
- rxd synchroniser: two flip-flops, both reset to 1; the FSM uses only the synchronised copy rxs.
- Bit period:
  - BIT = CLK_HZ/9600 or CLK_HZ/300, integer division.
  - HALF = BIT/2.
  - The selection is latched at start detection, so a baud_rate change mid-frame affects the next frame only.
  - Counter width is sized for CLK_HZ/300.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rxs 1→0 edge → START with cnt = HALF-1.
- START:
  - At cnt = 0, if rxs = 0 → DATA with cnt = BIT-1, bit index = 0.
  - Otherwise → IDLE (glitch rejected, no flags set).
- DATA:
  - At each cnt = 0, shift rxs in LSB-first and reload cnt = BIT-1.
  - After bit 7 → STOP.
- STOP, at cnt = 0:
  - rxs = 1 → frame accepted, return to IDLE.
  - rxs = 0 → set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stays until rxs = 1, then → IDLE. A break is not re-detected as a start bit.
- Store, at the cycle after the accepted stop sample. A byte is written only if all of these hold:
  - capture_en = 1;
  - ioctl_upload = 0;
  - the byte is not (DROP_NUL and byte = 0x00).
  - On write: mem[wr_ptr] ← byte, wr_ptr +1, and captured_len shows the new value on that same edge.
  - If wr_ptr = DEPTH: byte dropped, overflow set, wr_ptr holds (no wrap).
- Upload:
  - On ioctl_rd, ioctl_din is registered and valid 1 cycle later.
  - Value is mem[ioctl_addr] if ioctl_addr < captured_len, else 0x00.
  - ioctl_din holds between reads.
  - Bytes completing while ioctl_upload = 1 are discarded with no flag.
- clear:
  - Sets wr_ptr = 0, overflow = 0, frame_err = 0; FSM forced to IDLE, aborting any frame in flight.
  - clear has priority over a simultaneous store and over a simultaneous flag set.
- busy = (state != IDLE).

Decomposition:
- Package uk101_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - function bit_period(clk_hz, baud_sel);
  - constants BAUD_FAST = 9600 and BAUD_SLOW = 300.
- Sub-module ascii_capture_ram: simple dual-port inferred BRAM, DEPTH x 8.
  - Write port: from the FSM.
  - Read port: registered, with address = ioctl_addr[ADDR_W-1:0].
  - The upper-bound check stays in ascii_capture.

Test Plan (bench uses CLK_HZ = 96000, giving BIT = 10 at 9600 and 320 at 300):
- Send "HI\r" (0x48 0x49 0x0D) at 9600, capture_en = 1 → captured_len = 3. Upload reads of addr 0..3 return 0x48, 0x49, 0x0D, 0x00; each value appears 1 cycle after its ioctl_rd.
- Send 0x00 then 0x41 with DROP_NUL = 1 → captured_len = 1, mem[0] = 0x41.
- 3-cycle low glitch on rxd → no byte stored, frame_err = 0, busy returns to 0 within HALF cycles.
- Frame 0x55 with stop bit forced low, rxd held low 30 cycles, then frame 0x31 → frame_err = 1, captured_len = 1, mem[0] = 0x31.
- ADDR_W = 2: send 5 bytes → captured_len = 4, overflow = 1. Then pulse clear → captured_len = 0, overflow = 0. Clear asserted on a store cycle → captured_len = 0.
- baud_rate = 1: send 0x7E at 320 clocks/bit and capture it correctly. Toggle baud_rate mid-frame → current frame is still decoded at 300 baud. Assert n_reset low mid-frame → all outputs return to reset values immediately.
